dll_delay_trainer: RTL and testbench
====================================

Name: dll_delay_trainer

Overview:
- Calibration controller that sits directly upstream of the simulated DLL delay stage.
- Drives the DLL's reset, adjust and max-adjust inputs, and watches its lock output.
- Sweeps every delay tap and scores each one using a per-cycle data-compare result taken from the DLL's delayed data.
- Parks the DLL on the centre of the longest passing window, then reports the result.

Parameters:
MADJ, 64, taps per reference cycle; drives io_madj; legal 2..255
SAMPLES, 16, compare cycles per tap; a tap passes only if all of them are ok
LOCK_TIMEOUT, 256, max cycles waiting for lock after any adjust change (DLL needs >100 ref cycles)
RST_CYCLES, 4, cycles io_dll_reset is held high at the start of training

Ports:
clock  input  1  reference clock, same clock that feeds the DLL
reset  input  1  synchronous, active-high
io_start  input  1  single-cycle pulse that starts training; honoured only in IDLE/DONE/FAIL
io_dll_lock  input  1  lock flag from the DLL
io_sample_ok  input  1  1 = delayed data matched the expected pattern this cycle
io_dll_reset  output  1  DLL reset
io_adj  output  8  DLL delay adjust
io_madj  output  8  constant MADJ
io_busy  output  1  training in progress
io_done  output  1  training succeeded; held until the next start or reset
io_fail  output  1  training failed; held until the next start or reset
io_best_adj  output  8  chosen tap
io_win_len  output  8  length of the chosen passing window

Behaviour:
- Reset values, all registered, applied one cycle after reset is sampled high, including mid-sweep:
  - io_dll_reset=1, io_adj=0, io_madj=MADJ
  - io_busy=0, io_done=0, io_fail=0, io_best_adj=0, io_win_len=0
  - FSM in IDLE; all run counters cleared.
- States: IDLE, DLL_RST, WAIT_LOCK, SAMPLE, EVAL, FINAL_LOCK, DONE, FAIL.
- IDLE/DONE/FAIL + io_start:
  - go to DLL_RST; clear done, fail and the run registers; set busy=1.
  - io_start is ignored in every other state.
- DLL_RST: io_dll_reset=1 and io_adj=0 for RST_CYCLES cycles, then io_dll_reset=0 and go to WAIT_LOCK.
- WAIT_LOCK (entered after any io_adj change or DLL reset release):
  - io_dll_lock is ignored for the first 2 cycles (blanking), because the DLL drops lock one edge after an adjust change.
  - After blanking, io_dll_lock=1 moves to SAMPLE.
  - Timeout counter reaching LOCK_TIMEOUT moves to FAIL.
- SAMPLE: runs for exactly SAMPLES cycles. The tap fails if any cycle has io_sample_ok=0 or io_dll_lock=0.
- EVAL, one cycle:
  - On pass: if cur_len==0 then cur_start=io_adj; then cur_len++. If cur_len (new) > best_len (strict), best_len=cur_len and best_start=cur_start.
  - On fail: cur_len=0.
  - If io_adj==MADJ-1, go to final selection. Otherwise io_adj++ and go to WAIT_LOCK.
  - No wrap-around: a window never spans tap MADJ-1 to tap 0.
- Final selection:
  - best_len==0 goes to FAIL.
  - Otherwise io_best_adj = best_start + floor((best_len-1)/2), io_win_len=best_len, io_adj=io_best_adj, then FINAL_LOCK.
- Tie-break: the earliest window wins.
- FINAL_LOCK: same blanking and timeout as WAIT_LOCK. Lock goes to DONE (busy=0, done=1); timeout goes to FAIL.
- FAIL outputs: busy=0, fail=1, io_dll_reset=1, io_adj=0. io_best_adj and io_win_len are kept at their last values (0 if no window was found).
- DONE outputs: io_adj=io_best_adj and io_dll_reset=0 are held. Later lock loss does not clear io_done.
- Arithmetic: all counters are 8-bit (16-bit for timeout). Overflow cannot occur for legal MADJ.

Test Plan:
- Reset pulse mid-sweep (io_adj=17) -> next cycle: io_adj=0, io_dll_reset=1, busy/done/fail=0, io_madj=64.
- MADJ=64, SAMPLES=16, io_sample_ok=1 only for taps 20..30, DLL model locking -> io_best_adj=25, io_win_len=11, io_adj=25, io_done=1, io_dll_reset=0.
- Passing windows 5..8 and 40..43 (equal length 4) -> earliest window wins: io_best_adj=6, io_win_len=4.
- Window 20..30 with a single-cycle io_sample_ok=0 during tap 25 -> split into 20..24 and 26..30: io_best_adj=22, io_win_len=5.
- io_sample_ok always 0 -> after tap 63: io_fail=1, io_done=0, io_dll_reset=1, io_win_len=0.
- io_dll_lock stuck 0 -> io_fail=1 exactly LOCK_TIMEOUT (256) cycles after blanking ends on tap 0; io_start during busy is ignored, io_start in FAIL restarts training.

Source files
------------

// File: rtl/dll_delay_trainer.sv
// DLL delay trainer: sweeps every tap, scores each with SAMPLES compare cycles,
// then parks the DLL on the centre of the earliest longest passing window.
module dll_delay_trainer #(
  parameter int unsigned MADJ         = 64,
  parameter int unsigned SAMPLES      = 16,
  parameter int unsigned LOCK_TIMEOUT = 256,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_start,
  input  logic       io_dll_lock,
  input  logic       io_sample_ok,
  output logic       io_dll_reset,
  output logic [7:0] io_adj,
  output logic [7:0] io_madj,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_fail,
  output logic [7:0] io_best_adj,
  output logic [7:0] io_win_len
);

  localparam logic [7:0]  LastTap    = 8'(MADJ - 1);
  localparam logic [7:0]  SampLast   = 8'(SAMPLES - 1);
  localparam logic [7:0]  RstLast    = 8'(RST_CYCLES - 1);
  // Two blanking cycles precede LOCK_TIMEOUT lock checks.
  localparam logic [15:0] TimeoutEnd = 16'(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StDllRst, StWaitLock, StSample, StEval, StFinalLock, StDone, StFail
  } state_e;

  state_e      state;
  logic [7:0]  step_cnt;
  logic [15:0] wait_cnt;
  logic        tap_ok;
  logic [7:0]  cur_len, cur_start, best_len, best_start;

  logic [7:0]  cur_len_n, cur_start_n, best_len_n, best_start_n, centre;

  // Window bookkeeping for the tap being evaluated, including final selection.
  always_comb begin
    cur_start_n  = (cur_len == 8'd0) ? io_adj : cur_start;
    cur_len_n    = tap_ok ? cur_len + 8'd1 : 8'd0;
    best_len_n   = best_len;
    best_start_n = best_start;
    if (tap_ok && (cur_len_n > best_len)) begin
      best_len_n   = cur_len_n;
      best_start_n = cur_start_n;
    end
    centre = best_start_n + ((best_len_n - 8'd1) >> 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      step_cnt     <= '0;
      wait_cnt     <= '0;
      tap_ok       <= 1'b0;
      cur_len      <= '0;
      cur_start    <= '0;
      best_len     <= '0;
      best_start   <= '0;
      io_dll_reset <= 1'b1;
      io_adj       <= '0;
      io_madj      <= 8'(MADJ);
      io_busy      <= 1'b0;
      io_done      <= 1'b0;
      io_fail      <= 1'b0;
      io_best_adj  <= '0;
      io_win_len   <= '0;
    end else begin
      unique case (state)
        StIdle, StDone, StFail: begin
          if (io_start) begin
            state        <= StDllRst;
            step_cnt     <= '0;
            cur_len      <= '0;
            cur_start    <= '0;
            best_len     <= '0;
            best_start   <= '0;
            io_dll_reset <= 1'b1;
            io_adj       <= '0;
            io_busy      <= 1'b1;
            io_done      <= 1'b0;
            io_fail      <= 1'b0;
            io_best_adj  <= '0;
            io_win_len   <= '0;
          end
        end
        StDllRst: begin
          if (step_cnt == RstLast) begin
            io_dll_reset <= 1'b0;
            wait_cnt     <= '0;
            state        <= StWaitLock;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        StWaitLock, StFinalLock: begin
          // Lock is stale right after an adjust change, so it is blanked first.
          if (wait_cnt < 16'd2) begin
            wait_cnt <= wait_cnt + 16'd1;
          end else if (io_dll_lock) begin
            if (state == StWaitLock) begin
              state    <= StSample;
              step_cnt <= '0;
              tap_ok   <= 1'b1;
            end else begin
              state   <= StDone;
              io_busy <= 1'b0;
              io_done <= 1'b1;
            end
          end else if (wait_cnt == TimeoutEnd) begin
            state        <= StFail;
            io_busy      <= 1'b0;
            io_fail      <= 1'b1;
            io_dll_reset <= 1'b1;
            io_adj       <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        StSample: begin
          tap_ok <= tap_ok & io_sample_ok & io_dll_lock;
          if (step_cnt == SampLast) begin
            state <= StEval;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        StEval: begin
          cur_len    <= cur_len_n;
          cur_start  <= cur_start_n;
          best_len   <= best_len_n;
          best_start <= best_start_n;
          wait_cnt   <= '0;
          if (io_adj == LastTap) begin
            if (best_len_n == 8'd0) begin
              state        <= StFail;
              io_busy      <= 1'b0;
              io_fail      <= 1'b1;
              io_dll_reset <= 1'b1;
              io_adj       <= '0;
            end else begin
              io_best_adj <= centre;
              io_win_len  <= best_len_n;
              io_adj      <= centre;
              state       <= StFinalLock;
            end
          end else begin
            io_adj <= io_adj + 8'd1;
            state  <= StWaitLock;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dll_delay_trainer.sv
// Bench for dll_delay_trainer: behavioural DLL lock/data model, table of
// window patterns checked through a scoreboard, plus reset and timeout sequences.
module tb_dll_delay_trainer;

  localparam int LockDelay = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_start = 1'b0;
  logic       io_dll_lock = 1'b0;
  logic       io_sample_ok = 1'b0;
  logic       io_dll_reset, io_busy, io_done, io_fail;
  logic [7:0] io_adj, io_madj, io_best_adj, io_win_len;

  dll_delay_trainer #(
    .MADJ(64), .SAMPLES(16), .LOCK_TIMEOUT(256), .RST_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_dll_lock(io_dll_lock),
    .io_sample_ok(io_sample_ok), .io_dll_reset(io_dll_reset), .io_adj(io_adj),
    .io_madj(io_madj), .io_busy(io_busy), .io_done(io_done), .io_fail(io_fail),
    .io_best_adj(io_best_adj), .io_win_len(io_win_len)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;

  // DLL model: lock drops one edge after reset/adjust change, returns later.
  logic        stuck_low = 1'b0;
  logic [7:0]  prev_adj = '0;
  int          lock_cnt = 0;
  always @(posedge clock) begin
    prev_adj <= io_adj;
    if (stuck_low || io_dll_reset || io_adj != prev_adj) begin
      io_dll_lock <= 1'b0;
      lock_cnt    <= 0;
    end else if (lock_cnt < LockDelay) begin
      lock_cnt <= lock_cnt + 1;
    end else begin
      io_dll_lock <= 1'b1;
    end
  end

  // Data-compare model with an optional one-cycle glitch while on tap 25.
  logic [63:0] pass_mask = '0;
  bit          glitch_en = 1'b0;
  int          glitch_cnt = 0;
  always @(negedge clock) begin
    if (io_adj != 8'd25) glitch_cnt = 0;
    else if (io_dll_lock) glitch_cnt = glitch_cnt + 1;
    io_sample_ok = pass_mask[io_adj[5:0]] &&
                   !(glitch_en && io_adj == 8'd25 && glitch_cnt == 8);
  end

  typedef struct {
    int lo1, hi1, lo2, hi2;
    bit glitch;
    int e_done, e_fail, e_best, e_len;
  } vec_t;

  typedef struct {
    int e_done, e_fail, e_best, e_len;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got;
    bit   finished;
    for (int i = 0; i < 64; i++)
      pass_mask[i] = (i >= v.lo1 && i <= v.hi1) || (i >= v.lo2 && i <= v.hi2);
    glitch_en = v.glitch;
    e.e_done = v.e_done; e.e_fail = v.e_fail; e.e_best = v.e_best; e.e_len = v.e_len;
    sb_q.push_back(e);
    pulse_start();
    check($sformatf("v%0d busy_after_start", idx), int'(io_busy), 1);
    check($sformatf("v%0d fail_cleared", idx), int'(io_fail), 0);
    finished = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      if (io_done || io_fail) begin
        finished = 1'b1;
        break;
      end
    end
    check($sformatf("v%0d finished", idx), int'(finished), 1);
    got = sb_q.pop_front();
    check($sformatf("v%0d done", idx), int'(io_done), got.e_done);
    check($sformatf("v%0d fail", idx), int'(io_fail), got.e_fail);
    check($sformatf("v%0d best_adj", idx), int'(io_best_adj), got.e_best);
    check($sformatf("v%0d win_len", idx), int'(io_win_len), got.e_len);
    check($sformatf("v%0d busy_end", idx), int'(io_busy), 0);
    if (got.e_done == 1) begin
      check($sformatf("v%0d adj_parked", idx), int'(io_adj), got.e_best);
      check($sformatf("v%0d dll_reset_low", idx), int'(io_dll_reset), 0);
    end else begin
      check($sformatf("v%0d adj_zero", idx), int'(io_adj), 0);
      check($sformatf("v%0d dll_reset_high", idx), int'(io_dll_reset), 1);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    vec_t v;

    vecs[0] = '{20, 30, -1, -1, 1'b0, 1, 0, 25, 11};
    vecs[1] = '{5, 8, 40, 43, 1'b0, 1, 0, 6, 4};
    vecs[2] = '{20, 30, -1, -1, 1'b1, 1, 0, 22, 5};
    vecs[3] = '{-1, -1, -1, -1, 1'b0, 0, 1, 0, 0};
    vecs[4] = '{0, 63, -1, -1, 1'b0, 1, 0, 31, 64};
    vecs[5] = '{63, 63, -1, -1, 1'b0, 1, 0, 63, 1};
    vecs[6] = '{0, 1, 10, 12, 1'b0, 1, 0, 11, 3};
    vecs[7] = '{2, 3, 60, 63, 1'b0, 1, 0, 61, 4};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst dll_reset", int'(io_dll_reset), 1);
    check("rst adj", int'(io_adj), 0);
    check("rst madj", int'(io_madj), 64);
    check("rst busy", int'(io_busy), 0);
    check("rst done", int'(io_done), 0);
    check("rst fail", int'(io_fail), 0);
    check("rst best_adj", int'(io_best_adj), 0);
    check("rst win_len", int'(io_win_len), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of a sweep.
    pass_mask = '1;
    glitch_en = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clock);
      if (io_adj == 8'd17) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst reached tap 17", int'(seen), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst adj", int'(io_adj), 0);
    check("midrst dll_reset", int'(io_dll_reset), 1);
    check("midrst busy", int'(io_busy), 0);
    check("midrst done", int'(io_done), 0);
    check("midrst fail", int'(io_fail), 0);
    check("midrst madj", int'(io_madj), 64);

    // Lock never arrives: timeout on tap 0, with a start pulse that must be ignored.
    stuck_low = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (io_dll_reset == 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("stuck dll_reset released", int'(seen), 1);
    n = 0;
    seen = 1'b0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      if (n == 50) io_start = 1'b1;
      if (n == 51) begin
        io_start = 1'b0;
        check("stuck start ignored busy", int'(io_busy), 1);
        check("stuck start ignored dll_reset", int'(io_dll_reset), 0);
      end
      if (io_fail) begin
        seen = 1'b1;
        break;
      end
    end
    check("stuck fail seen", int'(seen), 1);
    check("stuck fail cycle", n, 258);
    check("stuck done", int'(io_done), 0);
    check("stuck dll_reset", int'(io_dll_reset), 1);
    check("stuck adj", int'(io_adj), 0);
    check("stuck win_len", int'(io_win_len), 0);

    // Restart from FAIL with a healthy DLL.
    stuck_low = 1'b0;
    v = '{33, 36, -1, -1, 1'b0, 1, 0, 34, 4};
    run_vec(v, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
